// File: rtl/cacheline_adapter_pkg.sv
// Shared types and constants for cacheline_adapter: FSM state encoding,
// line/beat geometry and the burst address alignment helper.
package cacheline_adapter_types;

    localparam int LINE_W      = 256;
    localparam int BURST_W     = 64;
    localparam int BURST_BEATS = 4;
    localparam int ADDR_W      = 32;

    localparam logic [1:0] LAST_BEAT = 2'(BURST_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A burst always starts on a 32-byte line boundary.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:5], 5'b00000};
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Converts 256-bit cache line requests into 4-beat 64-bit memory bursts.
// Optional burst counters are built when CACHELINE_ADAPTER_PERF_EN is defined.
module cacheline_adapter
    import cacheline_adapter_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
`ifdef CACHELINE_ADAPTER_PERF_EN
    ,
    output logic [31:0]        rd_bursts_o,
    output logic [31:0]        wr_bursts_o
`endif
);

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  wline_q, wline_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic               resp_q, resp_d;

    // Next-state, datapath and output decode; outputs are registered from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        line_d  = line_q;

        case (state_q)
            ST_IDLE: begin
                if (write_i) begin
                    state_d = ST_WRITE;
                    addr_d  = line_align(address_i);
                    wline_d = line_i;
                    cnt_d   = 2'd0;
                end else if (read_i) begin
                    state_d = ST_READ;
                    addr_d  = line_align(address_i);
                    cnt_d   = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (resp_i) begin
                    line_d[BURST_W*cnt_q +: BURST_W] = burst_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (resp_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                // Requests are only re-sampled from IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        read_d  = (state_d == ST_READ);
        write_d = (state_d == ST_WRITE);
        resp_d  = (state_d == ST_DONE);
        burst_d = wline_d[BURST_W*cnt_d +: BURST_W];
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= {ADDR_W{1'b0}};
            wline_q <= {LINE_W{1'b0}};
            line_q  <= {LINE_W{1'b0}};
            burst_q <= {BURST_W{1'b0}};
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            line_q  <= line_d;
            burst_q <= burst_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
        end
    end

    assign line_o    = line_q;
    assign burst_o   = burst_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

`ifdef CACHELINE_ADAPTER_PERF_EN
    logic [31:0] rd_bursts_q;
    logic [31:0] wr_bursts_q;

    // Saturating counts of completed read and write bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bursts_q <= 32'd0;
            wr_bursts_q <= 32'd0;
        end else begin
            if ((state_q == ST_READ) && (state_d == ST_DONE) && (rd_bursts_q != 32'hFFFF_FFFF)) begin
                rd_bursts_q <= rd_bursts_q + 32'd1;
            end else begin
                rd_bursts_q <= rd_bursts_q;
            end
            if ((state_q == ST_WRITE) && (state_d == ST_DONE) && (wr_bursts_q != 32'hFFFF_FFFF)) begin
                wr_bursts_q <= wr_bursts_q + 32'd1;
            end else begin
                wr_bursts_q <= wr_bursts_q;
            end
        end
    end

    assign rd_bursts_o = rd_bursts_q;
    assign wr_bursts_o = wr_bursts_q;
`endif

endmodule
